toggle_counter_mod: RTL and testbench

//  Parametrised successor to the single-bit toggle flip-flop. A WIDTH-bit

---
 rtl/toggle_counter_mod.sv | 66 ++++++
 tb/tb_toggle_counter_mod.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/toggle_counter_mod.sv
// WIDTH-bit modulo counter with enable, up/down, parallel load and tc strobe.
// Define TC_TOGGLE_EN to add the tq divide-by-2*MODULUS toggle output.
module toggle_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef TC_TOGGLE_EN
  ,
  output logic             tq
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  // One bit wider so MODULUS == 2**WIDTH is representable
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_d, q_q;
  logic             at_term;

  always_comb begin
    at_term = up ? (q_q == MAX_V) : (q_q == '0);
    tc      = enable & at_term;
    q_d     = q_q;
    if (load) begin
      q_d = ({1'b0, d} < MOD_W) ? d : MAX_V;
    end else if (enable) begin
      if (up) q_d = at_term ? '0 : q_q + ONE_V;
      else    q_d = at_term ? MAX_V : q_q - ONE_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= RST_V;
    else        q_q <= q_d;
  end

  assign q = q_q;

`ifdef TC_TOGGLE_EN
  logic tq_d, tq_q;

  always_comb begin
    tq_d = tq_q;
    if (!load && tc) tq_d = ~tq_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) tq_q <= 1'b0;
    else        tq_q <= tq_d;
  end

  assign tq = tq_q;
`endif

endmodule

// File: tb/tb_toggle_counter_mod.sv
// Scoreboard bench for toggle_counter_mod: driver queues expectations,
// monitor checks tc mid-cycle and q/tq just after each edge.
module tb_toggle_counter_mod;

  logic       clk = 1'b0;
  logic       reset, enable, up, load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
`ifdef TC_TOGGLE_EN
  logic       tq;
`endif

  toggle_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .up     (up),
    .load   (load),
    .d      (d),
    .q      (q),
    .tc     (tc)
`ifdef TC_TOGGLE_EN
    ,
    .tq     (tq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         tc_exp;
    logic [3:0] q_exp;
    logic       tq_exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic tq_m  = 1'b0;
  bit   drv_done = 0;

  task automatic step(input string nm, input logic rst, input logic en,
                      input logic u, input logic ld, input logic [3:0] dv,
                      input int tce, input logic [3:0] qe);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; enable = en; up = u; load = ld; d = dv;
    if (!rst) tq_m = 1'b0;
    else if (!ld && en && tce == 1) tq_m = ~tq_m;
    e.name = nm; e.tc_exp = tce; e.q_exp = qe; e.tq_exp = tq_m;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb[0];
        if (e.tc_exp >= 0) begin
          n_cmp++;
          if (tc !== e.tc_exp[0]) begin
            n_bad++;
            $display("FAIL %s tc: got %b want %0d", e.name, tc, e.tc_exp);
          end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (q !== e.q_exp) begin
          n_bad++;
          $display("FAIL %s q: got %0d want %0d", e.name, q, e.q_exp);
        end
`ifdef TC_TOGGLE_EN
        n_cmp++;
        if (tq !== e.tq_exp) begin
          n_bad++;
          $display("FAIL %s tq: got %b want %b", e.name, tq, e.tq_exp);
        end
`endif
        void'(sb.pop_front());
      end
    end
  end

  initial begin : driver
    logic [3:0] up_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    logic [3:0] qq;
    reset = 1'b0; enable = 1'b1; up = 1'b1; load = 1'b0; d = '0;
    // 1: reset holds q at 0 even with enable high
    step("rst0", 0, 1, 1, 0, 0, -1, 0);
    step("rst1", 0, 1, 1, 0, 0, 0, 0);
    // 2: count up with wrap, tc only at q==9
    for (int i = 0; i < 12; i++)
      step("up", 1, 1, 1, 0, 0, (i == 9) ? 1 : 0, up_q[i]);
    // 3: back to 0 by load, then count down through the wrap
    step("ld0", 1, 1, 1, 1, 0, 0, 0);
    step("dn0", 1, 1, 0, 0, 0, 1, 9);
    step("dn1", 1, 1, 0, 0, 0, 0, 8);
    step("dn2", 1, 1, 0, 0, 0, 0, 7);
    // 4: load, clamp, and tc independent of load
    step("ld6", 1, 1, 0, 1, 6, 0, 6);
    step("ld15", 1, 1, 1, 1, 15, 0, 9);
    step("ld9tc", 1, 1, 1, 1, 9, 1, 9);
    step("ld10", 1, 0, 1, 1, 10, 0, 9);
    step("dirchg", 1, 1, 0, 0, 0, 0, 8);
    // 5: hold with enable low, then reset mid-count
    step("ld4", 1, 0, 1, 1, 4, 0, 4);
    for (int i = 0; i < 5; i++)
      step("hold", 1, 0, 1, 0, 0, 0, 4);
    step("cnt5", 1, 1, 1, 0, 0, 0, 5);
    step("cnt6", 1, 1, 1, 0, 0, 0, 6);
    step("midrst", 0, 1, 1, 0, 0, 0, 0);
    step("ld9", 1, 0, 1, 1, 9, 0, 9);
    step("rsttc", 0, 1, 1, 0, 0, 1, 0);
    step("dnhold0", 1, 0, 0, 0, 0, 0, 0);
    // 6: long up-count for the toggle divider
    qq = 4'd0;
    for (int i = 0; i < 40; i++) begin
      step("div", 1, 1, 1, 0, 0, (qq == 9) ? 1 : 0,
           (qq == 9) ? 4'd0 : qq + 4'd1);
      qq = (qq == 9) ? 4'd0 : qq + 4'd1;
    end
    drv_done = 1;
  end

  initial begin : finisher
    int budget;
    wait (drv_done);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #3;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: time limit reached, want run complete");
    $fatal(1, "timeout");
  end

endmodule
